// File: rtl/bidir_bus_ctrl.sv
// Direction control for a half-duplex bidirectional buffer shared by sides A and B.
// Round-robin arbitration, turnaround dead cycles and burst limiting; BIDIR_TURN_STATS_EN adds turn_cnt/starve.
module bidir_bus_ctrl #(
  parameter int TURN_CYCLES = 1,
  parameter int MAX_BURST   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last_a,
  input  logic       last_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       dir,
  output logic       bus_en,
  output logic       busy,
  output logic [7:0] beat_cnt
`ifdef BIDIR_TURN_STATS_EN
  ,
  output logic [15:0] turn_cnt,
  output logic        starve
`endif
);

  typedef enum logic [1:0] {IDLE, TURN, OWN_A, OWN_B} state_t;

  localparam logic [7:0] MAX_B  = 8'(MAX_BURST);
  localparam logic [3:0] TURN_C = 4'(TURN_CYCLES);

  state_t     state_reg, state_next;
  logic       dir_reg, dir_next;
  logic       last_owner_reg, last_owner_next;  // 0 = A, 1 = B
  logic       pend_reg, pend_next;              // pending winner across TURN
  logic [3:0] turn_reg, turn_next;
  logic [7:0] beat_reg, beat_next;
  logic       gnt_a_reg, gnt_b_reg, bus_en_reg, busy_reg;

  logic       win, own_side, own_req, own_last, other_req, rel;
  logic [7:0] beat_inc;

  always_comb begin
    own_side  = (state_reg == OWN_B);
    own_req   = own_side ? req_b  : req_a;
    own_last  = own_side ? last_b : last_a;
    other_req = own_side ? req_a  : req_b;
    beat_inc  = (beat_reg >= MAX_B) ? MAX_B : beat_reg + 8'd1;
  end

  always_comb begin
    state_next      = state_reg;
    dir_next        = dir_reg;
    last_owner_next = last_owner_reg;
    pend_next       = pend_reg;
    turn_next       = turn_reg;
    beat_next       = beat_reg;
    win             = 1'b0;
    rel             = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_a || req_b) begin
          win = (req_a && req_b) ? ~last_owner_reg : req_b;
          if (win == dir_reg) begin
            state_next = win ? OWN_B : OWN_A;
          end else begin
            state_next = TURN;
            dir_next   = win;
            pend_next  = win;
            turn_next  = TURN_C;
          end
        end
      end
      TURN: begin
        if (turn_reg <= 4'd1) begin
          if (pend_reg ? req_b : req_a)
            state_next = pend_reg ? OWN_B : OWN_A;
          else
            state_next = IDLE;
        end else begin
          turn_next = turn_reg - 4'd1;
        end
      end
      OWN_A, OWN_B: begin
        if (!own_req) begin
          rel = 1'b1;
        end else begin
          beat_next = beat_inc;
          // last and a burst-limit preemption in the same beat collapse to one release
          if (own_last || (beat_inc == MAX_B && other_req))
            rel = 1'b1;
        end
        if (rel) begin
          last_owner_next = own_side;
          beat_next       = 8'd0;
          if (other_req) begin
            state_next = TURN;
            dir_next   = ~own_side;
            pend_next  = ~own_side;
            turn_next  = TURN_C;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      dir_reg        <= 1'b0;
      last_owner_reg <= 1'b1;
      pend_reg       <= 1'b0;
      turn_reg       <= 4'd0;
      beat_reg       <= 8'd0;
      gnt_a_reg      <= 1'b0;
      gnt_b_reg      <= 1'b0;
      bus_en_reg     <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dir_reg        <= dir_next;
      last_owner_reg <= last_owner_next;
      pend_reg       <= pend_next;
      turn_reg       <= turn_next;
      beat_reg       <= beat_next;
      gnt_a_reg      <= (state_next == OWN_A);
      gnt_b_reg      <= (state_next == OWN_B);
      bus_en_reg     <= (state_next == OWN_A) || (state_next == OWN_B);
      busy_reg       <= (state_next != IDLE);
    end
  end

  assign gnt_a    = gnt_a_reg;
  assign gnt_b    = gnt_b_reg;
  assign dir      = dir_reg;
  assign bus_en   = bus_en_reg;
  assign busy     = busy_reg;
  assign beat_cnt = beat_reg;

`ifdef BIDIR_TURN_STATS_EN
  localparam logic [10:0] STARVE_LIM = 11'(2 * MAX_BURST + TURN_CYCLES + 2);

  logic [15:0] turn_cnt_reg;
  logic        starve_reg;
  logic [1:0]  over;

  // Per-side wait counters: cycles spent requesting without owning the bus.
  for (genvar gi = 0; gi < 2; gi++) begin : g_wait
    logic [10:0] wait_reg;
    logic        side_req, side_own;
    assign side_req = (gi == 0) ? req_a : req_b;
    assign side_own = (state_reg == ((gi == 0) ? OWN_A : OWN_B));
    always_ff @(posedge clk) begin
      if (rst || !side_req || side_own)
        wait_reg <= 11'd0;
      else if (wait_reg != 11'h7FF)
        wait_reg <= wait_reg + 11'd1;
    end
    assign over[gi] = (wait_reg > STARVE_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      turn_cnt_reg <= 16'd0;
      starve_reg   <= 1'b0;
    end else begin
      if (state_next == TURN && state_reg != TURN && turn_cnt_reg != 16'hFFFF)
        turn_cnt_reg <= turn_cnt_reg + 16'd1;
      if (|over)
        starve_reg <= 1'b1;
    end
  end

  assign turn_cnt = turn_cnt_reg;
  assign starve   = starve_reg;
`endif

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Directed bench for bidir_bus_ctrl: default instance plus a TURN_CYCLES=3 instance on shared stimulus.
// Also exercises turn_cnt/starve when BIDIR_TURN_STATS_EN is defined.
module tb_bidir_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst, req_a, req_b, last_a, last_b;
  logic       gnt_a, gnt_b, dir, bus_en, busy;
  logic [7:0] beat_cnt;
  logic       t3_gnt_a, t3_gnt_b, t3_dir, t3_bus_en, t3_busy;
  logic [7:0] t3_beat_cnt;
`ifdef BIDIR_TURN_STATS_EN
  logic [15:0] turn_cnt, t3_turn_cnt;
  logic        starve, t3_starve;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  bidir_bus_ctrl dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .last_a(last_a), .last_b(last_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .dir(dir), .bus_en(bus_en), .busy(busy), .beat_cnt(beat_cnt)
`ifdef BIDIR_TURN_STATS_EN
    , .turn_cnt(turn_cnt), .starve(starve)
`endif
  );

  bidir_bus_ctrl #(.TURN_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .last_a(last_a), .last_b(last_b),
    .gnt_a(t3_gnt_a), .gnt_b(t3_gnt_b), .dir(t3_dir), .bus_en(t3_bus_en), .busy(t3_busy),
    .beat_cnt(t3_beat_cnt)
`ifdef BIDIR_TURN_STATS_EN
    , .turn_cnt(t3_turn_cnt), .starve(t3_starve)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Invariants on the default instance, sampled mid-cycle; one line per grant start.
  logic prev_en = 1'b0, prev_dir = 1'b0, prev_ga = 1'b0, prev_gb = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("mutex", 16'(gnt_a & gnt_b), 16'd0);
      chk("en_gnt", 16'(bus_en), 16'(gnt_a | gnt_b));
      chk("beat_le_max", 16'(beat_cnt > 8'd8), 16'd0);
      if (prev_en && bus_en) chk("dir_hold", 16'(dir), 16'(prev_dir));
      if (gnt_a && !prev_ga) $display("cycle %0d: grant A dir=%0d", cyc, dir);
      if (gnt_b && !prev_gb) $display("cycle %0d: grant B dir=%0d", cyc, dir);
    end
    prev_en  <= bus_en;
    prev_dir <= dir;
    prev_ga  <= gnt_a;
    prev_gb  <= gnt_b;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  logic [1:0] exp_pat [20];

  initial begin
    // Reset values
    do_reset();
    chk("rst_gnt_a", 16'(gnt_a), 16'd0);
    chk("rst_gnt_b", 16'(gnt_b), 16'd0);
    chk("rst_dir", 16'(dir), 16'd0);
    chk("rst_bus_en", 16'(bus_en), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_beat", 16'(beat_cnt), 16'd0);

    // A: 4 beats, last on beat 4, no turnaround needed
    req_a = 1'b1;
    tick();
    chk("a4_gnt", 16'(gnt_a), 16'd1);
    chk("a4_dir", 16'(dir), 16'd0);
    chk("a4_en", 16'(bus_en), 16'd1);
    tick(); tick(); tick();
    chk("a4_beat3", 16'(beat_cnt), 16'd3);
    last_a = 1'b1;
    tick();
    req_a = 1'b0; last_a = 1'b0;
    chk("a4_rel_busy", 16'(busy), 16'd0);
    chk("a4_rel_gnt", 16'(gnt_a), 16'd0);
    chk("a4_rel_beat", 16'(beat_cnt), 16'd0);

    // B after A: dir flips with bus off; 1 dead cycle (default), 3 dead cycles (dut3)
    req_b = 1'b1;
    tick();
    chk("t1_en", 16'(bus_en), 16'd0);
    chk("t1_dir", 16'(dir), 16'd1);
    chk("t1_busy", 16'(busy), 16'd1);
    chk("t3_dir", 16'(t3_dir), 16'd1);
    chk("t3_dead1", 16'(t3_gnt_b), 16'd0);
    tick();
    chk("t1_gnt_b", 16'(gnt_b), 16'd1);
    chk("t3_dead2", 16'(t3_gnt_b), 16'd0);
    tick();
    chk("t3_dead3", 16'(t3_bus_en), 16'd0);
    tick();
    chk("t3_gnt_b", 16'(t3_gnt_b), 16'd1);
    req_b = 1'b0;
    tick();
    chk("b_drop_busy", 16'(busy), 16'd0);
    chk("b_drop_dir", 16'(dir), 16'd1);

    // Tie from reset: A first, then B via TURN with no IDLE cycle
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    tick();
    chk("tie_gnt_a", 16'(gnt_a), 16'd1);
    chk("tie_gnt_b", 16'(gnt_b), 16'd0);
    tick();
    last_a = 1'b1;
    tick();
    req_a = 1'b0; last_a = 1'b0;
    chk("tie_turn_busy", 16'(busy), 16'd1);
    chk("tie_turn_en", 16'(bus_en), 16'd0);
    chk("tie_turn_dir", 16'(dir), 16'd1);
    tick();
    chk("tie_gnt_b2", 16'(gnt_b), 16'd1);
    req_b = 1'b0;
    tick();

    // Continuous contention: A8 / TURN / B8 / TURN / A...
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    for (int k = 0; k < 20; k++)
      exp_pat[k] = (k < 8) ? 2'b01 : (k == 8) ? 2'b00 : (k < 17) ? 2'b10 : (k == 17) ? 2'b00 : 2'b01;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("alt_%0d", k + 1), 16'({gnt_b, gnt_a}), 16'(exp_pat[k]));
      if (k == 7 || k == 16) chk($sformatf("alt_beat_%0d", k + 1), 16'(beat_cnt), 16'd7);
    end
`ifdef BIDIR_TURN_STATS_EN
    chk("alt_turns", turn_cnt, 16'd2);
    chk("alt_starve", 16'(starve), 16'd0);
`endif
    req_a = 1'b0; req_b = 1'b0;
    tick();

    // A alone saturates at 8; B raised after cycle 14 preempts on the next beat
    do_reset();
    req_a = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 9 || k == 12) chk($sformatf("sat_beat_%0d", k), 16'(beat_cnt), 16'd8);
    end
    chk("sat_gnt_a", 16'(gnt_a), 16'd1);
    req_b = 1'b1;
    tick();
    chk("pre_gnt_a", 16'(gnt_a), 16'd0);
    chk("pre_en", 16'(bus_en), 16'd0);
    chk("pre_dir", 16'(dir), 16'd1);
    chk("pre_beat", 16'(beat_cnt), 16'd0);
    tick();
    chk("pre_gnt_b", 16'(gnt_b), 16'd1);
    req_a = 1'b0; req_b = 1'b0;
    tick();

    // Reset in the middle of a B burst (beat 3), then a tie goes to A
    do_reset();
    req_b = 1'b1;
    tick(); tick(); tick(); tick();
    chk("mid_beat", 16'(beat_cnt), 16'd2);
`ifdef BIDIR_TURN_STATS_EN
    chk("mid_turns", turn_cnt, 16'd1);
`endif
    rst = 1'b1;
    tick();
    chk("mrst_gnt_b", 16'(gnt_b), 16'd0);
    chk("mrst_dir", 16'(dir), 16'd0);
    chk("mrst_en", 16'(bus_en), 16'd0);
    chk("mrst_busy", 16'(busy), 16'd0);
    chk("mrst_beat", 16'(beat_cnt), 16'd0);
`ifdef BIDIR_TURN_STATS_EN
    chk("mrst_turns", turn_cnt, 16'd0);
`endif
    rst = 1'b0; req_a = 1'b1;
    tick();
    chk("mrst_tie_a", 16'(gnt_a), 16'd1);
    chk("mrst_tie_b", 16'(gnt_b), 16'd0);
    req_a = 1'b0; req_b = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
